// File: rtl/valu_pkg.sv
// valu_pkg: op codes, FSM states, default sizes and op decode for vector_alu_seq.
// Optional feature macro: VALU_REDUCE_EN (enables the REDSUM reduction op).
package valu_pkg;

  localparam int DEF_ELEM_W    = 8;
  localparam int DEF_NUM_ELEMS = 16;
  localparam int DEF_NUM_LANES = 4;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_ADD    = 4'b0001,
    OP_SUB    = 4'b0010,
    OP_AND    = 4'b0011,
    OP_OR     = 4'b0100,
    OP_XOR    = 4'b0101,
    OP_SLL    = 4'b0110,
    OP_SRL    = 4'b0111,
    OP_MUL    = 4'b1000,
    OP_REDSUM = 4'b1001
  } valu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } valu_state_e;

  // True for op codes that need EXEC passes; NOP and unknown codes skip straight to DONE.
  function automatic logic op_is_valid(input logic [3:0] op);
    logic valid;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_MUL: valid = 1'b1;
`ifdef VALU_REDUCE_EN
      OP_REDSUM:              valid = 1'b1;
`endif
      default:                valid = 1'b0;
    endcase
    return valid;
  endfunction

endpackage

// File: rtl/valu_lane.sv
// valu_lane: one combinational element ALU (op, a, b -> y), unsigned and wrapping.
// Optional feature macro: VALU_REDUCE_EN (lane computes a+b for REDSUM).
module valu_lane
  import valu_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  logic [3:0]        op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y
);

  localparam int SH_W = (ELEM_W > 1) ? $clog2(ELEM_W) : 1;

  logic [SH_W-1:0] sh_s;

  // Shift distance is only the low bits of the B element
  assign sh_s = b[SH_W-1:0];

  // Element operation select; results truncated to ELEM_W bits
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:    y = a + b;
      OP_SUB:    y = a - b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_XOR:    y = a ^ b;
      OP_SLL:    y = a << sh_s;
      OP_SRL:    y = a >> sh_s;
      OP_MUL:    y = a * b;
`ifdef VALU_REDUCE_EN
      OP_REDSUM: y = a + b;
`endif
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/vector_alu_seq.sv
// vector_alu_seq: sequential vector ALU, NUM_LANES elements per pass, PASSES passes per op.
// Optional feature macro: VALU_REDUCE_EN (REDSUM accumulates all lane sums into element 0).
module vector_alu_seq
  import valu_pkg::*;
#(
  parameter int ELEM_W    = DEF_ELEM_W,
  parameter int NUM_ELEMS = DEF_NUM_ELEMS,
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    op,
  input  logic [NUM_ELEMS*ELEM_W-1:0]   src_a,
  input  logic [NUM_ELEMS*ELEM_W-1:0]   src_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_ELEMS*ELEM_W-1:0]   result,
  output logic                          busy
);

  localparam int PASSES = NUM_ELEMS / NUM_LANES;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int VEC_W  = NUM_ELEMS * ELEM_W;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  if (NUM_ELEMS % NUM_LANES != 0) begin : g_bad_cfg
    $error("vector_alu_seq: NUM_ELEMS must be a multiple of NUM_LANES");
  end

  valu_state_e       state_r, state_next_s;
  logic [3:0]        op_r;
  logic [VEC_W-1:0]  a_r, b_r;
  logic [PASS_W-1:0] pass_r;
  logic              accept_s;
  logic              is_red_s;

  logic [ELEM_W-1:0] a_grid_s [PASSES][NUM_LANES];
  logic [ELEM_W-1:0] b_grid_s [PASSES][NUM_LANES];
  logic [ELEM_W-1:0] res_r    [PASSES][NUM_LANES];
  logic [ELEM_W-1:0] lane_a_s [NUM_LANES];
  logic [ELEM_W-1:0] lane_b_s [NUM_LANES];
  logic [ELEM_W-1:0] lane_y_s [NUM_LANES];

  assign accept_s  = (state_r == ST_IDLE) && in_valid;
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);

  // View latched operands and the result register as [pass][lane] grids
  for (genvar p = 0; p < PASSES; p++) begin : g_pass
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_elem
      assign a_grid_s[p][l] = a_r[(p*NUM_LANES+l)*ELEM_W +: ELEM_W];
      assign b_grid_s[p][l] = b_r[(p*NUM_LANES+l)*ELEM_W +: ELEM_W];
      assign result[(p*NUM_LANES+l)*ELEM_W +: ELEM_W] = res_r[p][l];
    end
  end

  // Lane input mux picks the current pass's elements
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign lane_a_s[l] = a_grid_s[pass_r][l];
    assign lane_b_s[l] = b_grid_s[pass_r][l];
    valu_lane #(.ELEM_W(ELEM_W)) u_lane (
      .op (op_r),
      .a  (lane_a_s[l]),
      .b  (lane_b_s[l]),
      .y  (lane_y_s[l])
    );
  end

`ifdef VALU_REDUCE_EN
  logic [ELEM_W-1:0] acc_r, acc_next_s;

  assign is_red_s = (op_r == OP_REDSUM);

  // Running sum of this pass's lane results, wrapping at ELEM_W bits
  always_comb begin
    acc_next_s = acc_r;
    for (int l = 0; l < NUM_LANES; l++) begin
      acc_next_s = acc_next_s + lane_y_s[l];
    end
  end

  // Reduction accumulator: cleared on accept, updated each REDSUM pass
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (accept_s) begin
      acc_r <= '0;
    end else if (state_r == ST_EXEC && is_red_s) begin
      acc_r <= acc_next_s;
    end else begin
      acc_r <= acc_r;
    end
  end
`else
  assign is_red_s = 1'b0;
`endif

  // Next-state decode; NOP and unknown ops go straight to DONE with a zero result
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = op_is_valid(op) ? ST_EXEC : ST_DONE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (pass_r == LAST_PASS) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state, operand latch and pass counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 4'b0000;
      a_r     <= '0;
      b_r     <= '0;
      pass_r  <= '0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r   <= op;
        a_r    <= src_a;
        b_r    <= src_b;
        pass_r <= '0;
      end else if (state_r == ST_EXEC) begin
        pass_r <= pass_r + PASS_W'(1);
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  // Result register: cleared on accept, one pass of lane outputs written per EXEC cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_r <= '{default: '0};
    end else if (accept_s) begin
      res_r <= '{default: '0};
    end else if (state_r == ST_EXEC && !is_red_s) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        res_r[pass_r][l] <= lane_y_s[l];
      end
`ifdef VALU_REDUCE_EN
    end else if (state_r == ST_EXEC && pass_r == LAST_PASS) begin
      res_r[0][0] <= acc_next_s;
`endif
    end else begin
      res_r <= res_r;
    end
  end

endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: directed plus randomized checks of vector_alu_seq against an element-wise model.
// Optional feature macro: VALU_REDUCE_EN (selects the REDSUM expectations).
`timescale 1ns/1ps
module tb_vector_alu_seq;

  localparam int EW     = 8;
  localparam int NE     = 16;
  localparam int NL     = 4;
  localparam int PASSES = NE / NL;
  localparam int VW     = NE * EW;
  localparam int M      = 1 << EW;
`ifdef VALU_REDUCE_EN
  localparam bit REDUCE = 1'b1;
`else
  localparam bit REDUCE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, in_valid, out_ready;
  logic [3:0]    op;
  logic [VW-1:0] src_a, src_b;
  logic          in_ready, out_valid, busy;
  logic [VW-1:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vector_alu_seq #(.ELEM_W(EW), .NUM_ELEMS(NE), .NUM_LANES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  task automatic check_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] splat(input logic [EW-1:0] e);
    logic [VW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*EW +: EW] = e;
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*EW +: EW] = EW'($urandom);
    return v;
  endfunction

  function automatic bit op_ok(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd8) || (o == 4'd9 && REDUCE);
  endfunction

  // Reference: each element from the op's arithmetic definition, modulo 2**EW
  function automatic logic [VW-1:0] model(input logic [3:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    int unsigned ea, eb, e, sum;
    r   = '0;
    sum = 0;
    for (int i = 0; i < NE; i++) begin
      ea = a[i*EW +: EW];
      eb = b[i*EW +: EW];
      case (o)
        4'd1:    e = (ea + eb) % M;
        4'd2:    e = (ea + M - eb) % M;
        4'd3:    e = ea & eb;
        4'd4:    e = ea | eb;
        4'd5:    e = ea ^ eb;
        4'd6:    e = (ea << (eb % EW)) % M;
        4'd7:    e = ea >> (eb % EW);
        4'd8:    e = (ea * eb) % M;
        default: e = 0;
      endcase
      if (o == 4'd9) sum = sum + ea + eb;
      r[i*EW +: EW] = EW'(e);
    end
    if (o == 4'd9 && REDUCE) r[EW-1:0] = EW'(sum % M);
    return r;
  endfunction

  // One request: accept, scramble inputs, measure latency, check result, stall, then handshake
  task automatic run_req(input string tag, input logic [3:0] o, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input int hold, output logic [VW-1:0] got);
    logic [VW-1:0] exp;
    int            lat;
    exp = model(o, a, b);
    check_bit({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; op = o; src_a = a; src_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); src_a = rand_vec(); src_b = rand_vec();
    // edges after the accepting edge until out_valid is seen
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_int({tag, "_latency"}, lat, op_ok(o) ? PASSES : 0);
    got = result;
    check_vec({tag, "_result"}, result, exp);
    check_bit({tag, "_busy"}, busy, 1'b1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_vec({tag, "_hold_result"}, result, exp);
      check_bit({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check_bit({tag, "_post_in_ready"}, in_ready, 1'b1);
    check_bit({tag, "_post_out_valid"}, out_valid, 1'b0);
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] got, va, vb;
    int            seen, first, second, lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_vec("reset_result", result, '0);
    @(negedge clk); rst_n = 1'b1;

    // ADD wrap: 0xF0 + 0x20 -> 0x10
    run_req("add_wrap", 4'd1, splat(8'hF0), splat(8'h20), 0, got);
    check_vec("add_wrap_const", got, splat(8'h10));

    // SLL by element index, SRL 0x80 by 7
    for (int i = 0; i < NE; i++) vb[i*EW +: EW] = EW'(i);
    va = splat(8'h01);
    run_req("sll_idx", 4'd6, va, vb, 0, got);
    for (int i = 0; i < NE; i++) va[i*EW +: EW] = EW'(1 << (i % 8));
    check_vec("sll_idx_const", got, va);
    run_req("srl_7", 4'd7, splat(8'h80), splat(8'h07), 0, got);
    check_vec("srl_7_const", got, splat(8'h01));

    // MUL wrap and invalid op
    run_req("mul", 4'd8, splat(8'h13), splat(8'h11), 0, got);
    check_vec("mul_const", got, splat(8'h43));
    run_req("inv_op", 4'hF, rand_vec(), rand_vec(), 0, got);
    check_vec("inv_op_zero", got, '0);
    run_req("nop", 4'd0, rand_vec(), rand_vec(), 0, got);

    // Long back-pressure stall
    run_req("stall10", 4'd2, rand_vec(), rand_vec(), 10, got);

    // REDSUM of element indices
    for (int i = 0; i < NE; i++) va[i*EW +: EW] = EW'(i);
    run_req("redsum", 4'd9, va, '0, 0, got);
    check_vec("redsum_const", got, REDUCE ? {{(VW-EW){1'b0}}, 8'h78} : '0);

    // Reset during EXEC pass 2 aborts the op
    @(negedge clk);
    in_valid = 1'b1; op = 4'd1; src_a = rand_vec(); src_b = rand_vec(); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_bit("abort_in_ready", in_ready, 1'b1);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    check_vec("abort_result", result, '0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_int("abort_no_out_valid", seen, 0);
    @(negedge clk); out_ready = 1'b0;
    run_req("after_abort_add", 4'd1, rand_vec(), rand_vec(), 0, got);

    // Throughput: request held valid, consumer always ready
    @(negedge clk);
    in_valid = 1'b1; op = 4'd5; src_a = rand_vec(); src_b = rand_vec(); out_ready = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 40 && second < 0; c++) begin
      if (in_ready && in_valid) begin
        if (first < 0) first = c;
        else second = c;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_int("throughput_spacing", second - first, PASSES + 2);
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    check_bit("throughput_drain", in_ready, 1'b1);

    // Randomized ops, operands and stalls
    for (int t = 0; t < 24; t++) begin
      run_req("rand", 4'($urandom_range(0, 15)), rand_vec(), rand_vec(), $urandom_range(0, 3), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
